seq_negate: RTL and testbench

SEQ_NEGATE -- requirements
Module: seq_negate

---
 rtl/seq_negate_if.sv | 23 ++
 rtl/seq_negate.sv | 93 +++++++++
 tb/tb_seq_negate.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_negate_if.sv
// Handshake bundle for the serial negate unit.
// master drives start/mode/in; slave returns busy/done/out/V.
interface seq_negate_if #(
  parameter int N = 4
);
  logic         start;
  logic [1:0]   mode;
  logic [N-1:0] in;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         V;

  modport master (
    output start, mode, in,
    input  busy, done, out, V
  );

  modport slave (
    input  start, mode, in,
    output busy, done, out, V
  );
endinterface

// File: rtl/seq_negate.sv
// Bit-serial two's-complement negate / abs / pass, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave: start/mode/in -> busy/done/out/V).
module seq_negate #(
  parameter int N = 4
) (
  input logic        clk,
  input logic        rst,
  seq_negate_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam word_t MINV = word_t'(1) << (N - 1);

  state_t        st;
  word_t         a;
  word_t         acc;
  word_t         acc_n;
  word_t         out_q;
  logic          neg;
  logic          carry;
  logic          v_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cnt;
  logic          abit;
  logic          obit;
  logic          last;

  // Effective negate was resolved at latch time, so the
  // per-bit rule only needs the neg flag.
  always_comb begin
    abit  = a[cnt];
    obit  = neg ? (~abit ^ carry) : abit;
    acc_n = acc;
    acc_n[cnt] = obit;
    last  = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      a      <= '0;
      acc    <= '0;
      out_q  <= '0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      v_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE, DONE: begin
          if (bus.start) begin
            st     <= RUN;
            a      <= bus.in;
            neg    <= (bus.mode == 2'b00) |
                      ((bus.mode == 2'b01) & bus.in[N-1]);
            cnt    <= '0;
            acc    <= '0;
            carry  <= 1'b1;
            busy_q <= 1'b1;
          end else begin
            st <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_n;
          carry <= ~abit & carry;
          cnt   <= cnt + CW'(1);
          // out only moves here so RUN never shows partial bits
          if (last) begin
            st     <= DONE;
            out_q  <= acc_n;
            v_q    <= neg & (a == MINV);
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.V    = v_q;
endmodule

// File: tb/tb_seq_negate.sv
// Directed bench for seq_negate at N=4, N=1 and N=8.
// Immediate assertions at every check, one summary line at end.
module tb_seq_negate;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [3:0] prev4 = '0;
  int   hn;
  int   hb;
  int   seen;

  always #5 clk = ~clk;

  seq_negate_if #(.N(4)) b4 ();
  seq_negate_if #(.N(1)) b1 ();
  seq_negate_if #(.N(8)) b8 ();

  seq_negate #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  seq_negate #(.N(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  seq_negate #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input logic [1:0] m,
                     input logic [3:0] x,
                     input logic [3:0] eo,
                     input logic ev,
                     input string tag);
    int n;
    int bc;
    b4.start = 1'b1;
    b4.mode  = m;
    b4.in    = x;
    @(posedge clk); #1;
    b4.start = 1'b0;
    b4.in    = ~x;
    n = 0;
    bc = 0;
    while (!b4.done && n < 20) begin
      if (b4.busy) bc++;
      if (n == 2) chk({tag, "_hold"}, b4.out, prev4);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_busyn"}, bc, 4);
    chk({tag, "_out"}, b4.out, eo);
    chk({tag, "_v"}, b4.V, ev);
    chk({tag, "_busy0"}, b4.busy, 0);
    prev4 = eo;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, b4.done, 0);
    chk({tag, "_keep"}, b4.out, eo);
  endtask

  task automatic op1(input logic [1:0] m,
                     input logic x,
                     input logic eo,
                     input logic ev,
                     input string tag);
    int n;
    b1.start = 1'b1;
    b1.mode  = m;
    b1.in    = x;
    @(posedge clk); #1;
    b1.start = 1'b0;
    n = 0;
    while (!b1.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_out"}, b1.out, eo);
    chk({tag, "_v"}, b1.V, ev);
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic [1:0] m,
                     input logic [7:0] x,
                     input logic [7:0] eo,
                     input logic ev,
                     input string tag);
    int n;
    b8.start = 1'b1;
    b8.mode  = m;
    b8.in    = x;
    @(posedge clk); #1;
    b8.start = 1'b0;
    n = 0;
    while (!b8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_out"}, b8.out, eo);
    chk({tag, "_v"}, b8.V, ev);
    @(posedge clk); #1;
    chk({tag, "_keep"}, b8.out, eo);
  endtask

  initial begin
    b4.start = 1'b0; b4.mode = 2'b00; b4.in = '0;
    b1.start = 1'b0; b1.mode = 2'b00; b1.in = '0;
    b8.start = 1'b0; b8.mode = 2'b00; b8.in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", b4.busy, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_out", b4.out, 0);
    chk("rst_v", b4.V, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op4(2'b00, 4'b0000, 4'b0000, 1'b0, "neg0");
    op4(2'b00, 4'b0001, 4'b1111, 1'b0, "neg1");
    op4(2'b00, 4'b0010, 4'b1110, 1'b0, "neg2");
    op4(2'b00, 4'b1111, 4'b0001, 1'b0, "negm1");
    op4(2'b00, 4'b0111, 4'b1001, 1'b0, "neg7");
    op4(2'b00, 4'b1000, 4'b1000, 1'b1, "negmin");
    op4(2'b00, 4'b1010, 4'b0110, 1'b0, "negA");
    op4(2'b00, 4'b1100, 4'b0100, 1'b0, "negC");

    op4(2'b01, 4'b1010, 4'b0110, 1'b0, "absA");
    op4(2'b01, 4'b0101, 4'b0101, 1'b0, "abs5");
    op4(2'b01, 4'b1000, 4'b1000, 1'b1, "absmin");
    op4(2'b10, 4'b1000, 4'b1000, 1'b0, "pass8");
    op4(2'b11, 4'b1000, 4'b1000, 1'b0, "rsv8");

    // start held through RUN, operand changed mid-op
    b4.start = 1'b1;
    b4.mode  = 2'b00;
    b4.in    = 4'b0011;
    @(posedge clk); #1;
    b4.in = 4'b0101;
    hn = 0;
    hb = 0;
    while (!b4.done && hn < 20) begin
      if (b4.busy) hb++;
      @(posedge clk); #1;
      hn++;
    end
    chk("hs_lat", hn, 4);
    chk("hs_busyn", hb, 4);
    chk("hs_out", b4.out, 4'b1101);
    @(posedge clk); #1;
    chk("b2b_busy", b4.busy, 1);
    chk("b2b_done", b4.done, 0);
    b4.start = 1'b0;
    hn = 0;
    while (!b4.done && hn < 20) begin
      @(posedge clk); #1;
      hn++;
    end
    chk("b2b_lat", hn, 4);
    chk("b2b_out", b4.out, 4'b1011);
    chk("b2b_v", b4.V, 0);
    @(posedge clk); #1;
    prev4 = 4'b1011;

    // reset on the second RUN cycle
    b4.start = 1'b1;
    b4.mode  = 2'b00;
    b4.in    = 4'b0011;
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_out", b4.out, 0);
    chk("mrst_v", b4.V, 0);
    chk("mrst_busy", b4.busy, 0);
    chk("mrst_done", b4.done, 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b4.done) seen = 1;
    end
    chk("mrst_nodone", seen, 0);
    prev4 = 4'b0000;
    op4(2'b00, 4'b0011, 4'b1101, 1'b0, "after_rst");

    op1(2'b00, 1'b1, 1'b1, 1'b1, "n1_neg1");
    op1(2'b00, 1'b0, 1'b0, 1'b0, "n1_neg0");
    op1(2'b10, 1'b1, 1'b1, 1'b0, "n1_pass");

    op8(2'b00, 8'h80, 8'h80, 1'b1, "n8_min");
    op8(2'b00, 8'h05, 8'hFB, 1'b0, "n8_neg5");
    op8(2'b01, 8'hF0, 8'h10, 1'b0, "n8_abs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
